// File: rtl/vga_frame_tx_if.sv
// Pixel-source and VGA-pin bundle for vga_frame_tx.
// master = the transmitter, slave = framebuffer RAM plus the monitor/DAC side.
interface vga_frame_tx_if;
  logic        PATTERN;
  logic [18:0] RD_ADDR;
  logic        RD_EN;
  logic [23:0] RD_DATA;
  logic        VGA_CLK;
  logic        VGA_HS;
  logic        VGA_VS;
  logic        VGA_BLANK_N;
  logic [7:0]  VGA_R;
  logic [7:0]  VGA_G;
  logic [7:0]  VGA_B;
  logic        FRAME_START;

  modport master (
    input  PATTERN, RD_DATA,
    output RD_ADDR, RD_EN, VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N,
           VGA_R, VGA_G, VGA_B, FRAME_START
  );

  modport slave (
    output PATTERN, RD_DATA,
    input  RD_ADDR, RD_EN, VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N,
           VGA_R, VGA_G, VGA_B, FRAME_START
  );
endinterface

// File: rtl/vga_frame_tx.sv
// VGA transmitter: stage-0 raster counters drive the framebuffer read,
// stage-1 registers sync/blank/bar colour so pins lag the counters by one clock.
module vga_frame_tx #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter int unsigned BOTTOM_UP = 1
) (
  input  logic           CLOCK_25,
  input  logic           RESET,
  vga_frame_tx_if.master bus
);

  localparam int unsigned HW       = 10;
  localparam int unsigned VW       = 10;
  localparam int unsigned AW       = 19;
  localparam int unsigned PW       = 24;
  localparam int unsigned CW       = 8;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_STOP  = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_STOP  = VS_START + V_SYNC;
  localparam int unsigned BAR_W    = H_ACTIVE / 8;

  // stage 0
  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic          active_c;
  logic          hs_c;
  logic          vs_c;
  logic          first_c;
  logic          rd_en_c;
  logic [VW-1:0] row_c;
  logic [AW-1:0] addr_c;
  logic [2:0]    bar_idx_c;
  logic [PW-1:0] bar_c;

  // stage 1
  logic          hs_q;
  logic          vs_q;
  logic          blank_n_q;
  logic          frame_start_q;
  logic          pattern_q;
  logic [PW-1:0] bar_q;
  logic [PW-1:0] pix_c;

  // Raster counters, origin at the first active pixel.
  always_ff @(posedge CLOCK_25) begin
    if (RESET) begin
      h <= '0;
      v <= '0;
    end else if (h == HW'(H_TOTAL - 1)) begin
      h <= '0;
      if (v == VW'(V_TOTAL - 1)) v <= '0;
      else                       v <= v + VW'(1);
    end else begin
      h <= h + HW'(1);
    end
  end

  always_comb begin
    active_c = (h < HW'(H_ACTIVE)) && (v < VW'(V_ACTIVE));
    hs_c     = (h >= HW'(HS_START)) && (h < HW'(HS_STOP));
    vs_c     = (v >= VW'(VS_START)) && (v < VW'(VS_STOP));
    first_c  = (h == '0) && (v == '0);
    row_c    = (BOTTOM_UP != 0) ? (VW'(V_ACTIVE - 1) - v) : v;
    // row*640 as two shifts; line pitch is fixed at 640 words
    addr_c   = (AW'(row_c) << 9) + (AW'(row_c) << 7) + AW'(h);
    rd_en_c  = active_c && !RESET;
  end

  // Colour bars: white, yellow, cyan, green, magenta, red, blue, black ({B,G,R}).
  always_comb begin
    bar_idx_c = 3'd7;
    bar_c     = '0;
    for (int i = 7; i >= 0; i--) begin
      if (h < HW'((i + 1) * BAR_W)) bar_idx_c = 3'(i);
    end
    case (bar_idx_c)
      3'd0:    bar_c = 24'hFF_FF_FF;
      3'd1:    bar_c = 24'h00_FF_FF;
      3'd2:    bar_c = 24'hFF_FF_00;
      3'd3:    bar_c = 24'h00_FF_00;
      3'd4:    bar_c = 24'hFF_00_FF;
      3'd5:    bar_c = 24'h00_00_FF;
      3'd6:    bar_c = 24'hFF_00_00;
      default: bar_c = 24'h00_00_00;
    endcase
  end

  always_ff @(posedge CLOCK_25) begin
    if (RESET) begin
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      blank_n_q     <= 1'b0;
      frame_start_q <= 1'b0;
      pattern_q     <= 1'b0;
      bar_q         <= '0;
    end else begin
      hs_q          <= !hs_c;
      vs_q          <= !vs_c;
      blank_n_q     <= active_c;
      frame_start_q <= first_c;
      pattern_q     <= bus.PATTERN;
      bar_q         <= bar_c;
    end
  end

  // RAM word arrives in the same cycle as its stage-1 pixel, so it is muxed straight out.
  assign pix_c = pattern_q ? bar_q : bus.RD_DATA;

  assign bus.RD_EN       = rd_en_c;
  assign bus.RD_ADDR     = rd_en_c ? addr_c : '0;
  assign bus.VGA_CLK     = CLOCK_25;
  assign bus.VGA_HS      = hs_q;
  assign bus.VGA_VS      = vs_q;
  assign bus.VGA_BLANK_N = blank_n_q;
  assign bus.FRAME_START = frame_start_q;
  assign bus.VGA_R       = blank_n_q ? pix_c[CW-1:0]    : '0;
  assign bus.VGA_G       = blank_n_q ? pix_c[2*CW-1:CW] : '0;
  assign bus.VGA_B       = blank_n_q ? pix_c[PW-1:2*CW] : '0;

endmodule

// File: tb/tb_vga_frame_tx.sv
// Directed bench for vga_frame_tx with a shortened vertical raster (12 active lines,
// 16 total) and full 800-clock lines, so whole frames fit in a short run.
module tb_vga_frame_tx;

  localparam int H_TOT = 800;
  localparam int V_ACT = 12;
  localparam int V_TOT = 16;
  localparam int FRAME = H_TOT * V_TOT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   out_idx = -1;

  vga_frame_tx_if bus();

  vga_frame_tx #(
    .V_ACTIVE(12), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut (
    .CLOCK_25(clk),
    .RESET   (rst),
    .bus     (bus)
  );

  always #20 clk = ~clk;

  // Framebuffer stand-in: 1-cycle read latency, {B,G,R} = {addr[7:0], addr[15:8], 5A}.
  always @(posedge clk) begin
    if (bus.RD_EN) bus.RD_DATA <= {bus.RD_ADDR[7:0], bus.RD_ADDR[15:8], 8'h5A};
  end

  // Raster index of the pixel currently on the pins (-1 while in reset).
  always @(posedge clk) begin
    out_idx <= rst ? -1 : (out_idx + 1) % FRAME;
  end

  function automatic logic [18:0] exp_addr(input int x, input int y);
    if (x < 640 && y < V_ACT) return 19'((V_ACT - 1 - y) * 640 + x);
    return '0;
  endfunction

  // Expected {R,G,B} for framebuffer source.
  function automatic logic [23:0] exp_ram_rgb(input int x, input int y);
    logic [18:0] a;
    a = exp_addr(x, y);
    if (x < 640 && y < V_ACT) return {8'h5A, a[15:8], a[7:0]};
    return '0;
  endfunction

  task automatic wait_out(input int target);
    int k;
    k = 0;
    while (out_idx != target && k <= FRAME) begin
      @(negedge clk);
      k++;
    end
    if (out_idx != target) begin
      checks++;
      errors++;
      $display("FAIL wait_out: out_idx=%0d want %0d", out_idx, target);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.PATTERN = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.VGA_HS, bus.VGA_VS, bus.VGA_BLANK_N, bus.FRAME_START, bus.RD_EN} !== 5'b11000 ||
          {bus.VGA_R, bus.VGA_G, bus.VGA_B} !== 24'h0 || bus.RD_ADDR !== 19'd0) begin
        errors++;
        $display("FAIL reset_hold cyc %0d: hs/vs/bl/fs/en=%b rgb=%h addr=%0d want 11000 000000 0",
                 i, {bus.VGA_HS, bus.VGA_VS, bus.VGA_BLANK_N, bus.FRAME_START, bus.RD_EN},
                 {bus.VGA_R, bus.VGA_G, bus.VGA_B}, bus.RD_ADDR);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.VGA_BLANK_N, bus.FRAME_START} !== 2'b11) begin
      errors++;
      $display("FAIL first_pixel_flags: blank_n/fs=%b want 11", {bus.VGA_BLANK_N, bus.FRAME_START});
    end
    checks++;
    if ({bus.VGA_R, bus.VGA_G, bus.VGA_B} !== 24'h5A1B80) begin
      errors++;
      $display("FAIL first_pixel_rgb: %h want 5a1b80", {bus.VGA_R, bus.VGA_G, bus.VGA_B});
    end
  endtask

  // Two full frames: syncs, blanking, frame pulse, RAM pixels and read address every clock.
  task automatic test_frame_timing();
    int x, y, m, xm, ym;
    int blank_hi, hs_lo, vs_lo, fs_cnt, blank_rise, blank_fall_n, hs_off, last_fs;
    int sync_bad, pix_bad;
    logic e_blank, e_hs, e_vs, e_fs, e_en, prev_blank, prev_hs;
    last_fs = -1;
    for (int f = 0; f < 2; f++) begin
      blank_hi = 0; hs_lo = 0; vs_lo = 0; fs_cnt = 0; blank_rise = 0;
      blank_fall_n = -1; hs_off = -1; prev_blank = 1'b0; prev_hs = 1'b1;
      sync_bad = 0; pix_bad = 0;
      for (int n = 0; n < FRAME; n++) begin
        if (!(f == 0 && n == 0)) @(negedge clk);
        x  = n % H_TOT;
        y  = n / H_TOT;
        m  = (n + 1) % FRAME;
        xm = m % H_TOT;
        ym = m / H_TOT;
        e_blank = (x < 640) && (y < V_ACT);
        e_hs    = !(x >= 656 && x < 752);
        e_vs    = !(y == 13 || y == 14);
        e_fs    = (n == 0);
        e_en    = (xm < 640) && (ym < V_ACT);
        if ({bus.VGA_HS, bus.VGA_VS, bus.VGA_BLANK_N, bus.FRAME_START} !== {e_hs, e_vs, e_blank, e_fs})
          sync_bad++;
        if ({bus.VGA_R, bus.VGA_G, bus.VGA_B} !== exp_ram_rgb(x, y) ||
            bus.RD_EN !== e_en || bus.RD_ADDR !== exp_addr(xm, ym))
          pix_bad++;
        if (bus.VGA_BLANK_N === 1'b1) blank_hi++;
        if (bus.VGA_HS === 1'b0) hs_lo++;
        if (bus.VGA_VS === 1'b0) vs_lo++;
        if (bus.VGA_BLANK_N === 1'b1 && prev_blank === 1'b0) blank_rise++;
        if (y == 0 && prev_blank === 1'b1 && bus.VGA_BLANK_N === 1'b0) blank_fall_n = n;
        if (y == 0 && prev_hs === 1'b1 && bus.VGA_HS === 1'b0) hs_off = n - blank_fall_n;
        if (bus.FRAME_START === 1'b1) begin
          fs_cnt++;
          if (last_fs >= 0) begin
            checks++;
            if (f * FRAME + n - last_fs !== FRAME) begin
              errors++;
              $display("FAIL fs_period: %0d want %0d", f * FRAME + n - last_fs, FRAME);
            end
          end
          last_fs = f * FRAME + n;
        end
        prev_blank = bus.VGA_BLANK_N;
        prev_hs    = bus.VGA_HS;
        if (x == H_TOT - 1) begin
          checks++;
          if (sync_bad !== 0) begin
            errors++;
            $display("FAIL sync_line f%0d y%0d: %0d bad clocks want 0", f, y, sync_bad);
          end
          checks++;
          if (pix_bad !== 0) begin
            errors++;
            $display("FAIL pixel_line f%0d y%0d: %0d bad clocks want 0", f, y, pix_bad);
          end
          sync_bad = 0;
          pix_bad  = 0;
        end
      end
      checks++;
      if (blank_hi !== V_ACT * 640) begin
        errors++; $display("FAIL blank_high f%0d: %0d want %0d", f, blank_hi, V_ACT * 640);
      end
      checks++;
      if (hs_lo !== V_TOT * 96) begin
        errors++; $display("FAIL hs_low f%0d: %0d want %0d", f, hs_lo, V_TOT * 96);
      end
      checks++;
      if (vs_lo !== 1600) begin
        errors++; $display("FAIL vs_low f%0d: %0d want 1600", f, vs_lo);
      end
      checks++;
      if (fs_cnt !== 1) begin
        errors++; $display("FAIL fs_count f%0d: %0d want 1", f, fs_cnt);
      end
      checks++;
      if (blank_rise !== V_ACT) begin
        errors++; $display("FAIL blank_pulses f%0d: %0d want %0d", f, blank_rise, V_ACT);
      end
      checks++;
      if (hs_off !== 16) begin
        errors++; $display("FAIL hs_offset f%0d: %0d want 16", f, hs_off);
      end
    end
  endtask

  // Read-address corners; targets are the output index one before the stage-0 pixel.
  task automatic test_addr();
    int          tgt  [6];
    logic [19:0] want [6];
    tgt  = '{FRAME - 1, 638, 639, 8799, 9438, 9599};
    want = '{{1'b1, 19'd7040}, {1'b1, 19'd7679}, {1'b0, 19'd0},
             {1'b1, 19'd0},    {1'b1, 19'd639},  {1'b0, 19'd0}};
    for (int i = 0; i < 6; i++) begin
      wait_out(tgt[i]);
      checks++;
      if ({bus.RD_EN, bus.RD_ADDR} !== want[i]) begin
        errors++;
        $display("FAIL rd_addr_%0d: en=%b addr=%0d want en=%b addr=%0d",
                 i, bus.RD_EN, bus.RD_ADDR, want[i][19], want[i][18:0]);
      end
    end
  endtask

  task automatic test_pattern();
    int          tgt  [6];
    logic [23:0] want [6];
    bus.PATTERN = 1'b1;
    tgt  = '{8000, 8080, 8160, 8400, 8600, 9100};
    want = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'hFF0000, 24'h000000, 24'h00FF00};
    for (int i = 0; i < 6; i++) begin
      wait_out(tgt[i]);
      checks++;
      if ({bus.VGA_R, bus.VGA_G, bus.VGA_B} !== want[i]) begin
        errors++;
        $display("FAIL bar_x%0d: rgb=%h want %h", tgt[i] % H_TOT, {bus.VGA_R, bus.VGA_G, bus.VGA_B}, want[i]);
      end
    end
    bus.PATTERN = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.VGA_R, bus.VGA_G, bus.VGA_B} !== 24'h5A012D) begin
      errors++;
      $display("FAIL pattern_switch_x301: rgb=%h want 5a012d", {bus.VGA_R, bus.VGA_G, bus.VGA_B});
    end
  endtask

  task automatic test_reset_mid_frame();
    int x, y, bad;
    wait_out(5119);
    checks++;
    if ({bus.VGA_BLANK_N, bus.VGA_R, bus.VGA_G, bus.VGA_B} !== {1'b1, 24'h5A0DBF}) begin
      errors++;
      $display("FAIL pre_reset_pixel: bl=%b rgb=%h want 1 5a0dbf",
               bus.VGA_BLANK_N, {bus.VGA_R, bus.VGA_G, bus.VGA_B});
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.VGA_HS, bus.VGA_VS, bus.VGA_BLANK_N, bus.FRAME_START, bus.RD_EN} !== 5'b11000 ||
        {bus.VGA_R, bus.VGA_G, bus.VGA_B} !== 24'h0 || bus.RD_ADDR !== 19'd0) begin
      errors++;
      $display("FAIL mid_reset_values: hs/vs/bl/fs/en=%b rgb=%h addr=%0d want 11000 000000 0",
               {bus.VGA_HS, bus.VGA_VS, bus.VGA_BLANK_N, bus.FRAME_START, bus.RD_EN},
               {bus.VGA_R, bus.VGA_G, bus.VGA_B}, bus.RD_ADDR);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.VGA_BLANK_N, bus.FRAME_START, bus.VGA_R, bus.VGA_G, bus.VGA_B} !== {2'b11, 24'h5A1B80}) begin
      errors++;
      $display("FAIL restart_pixel: bl/fs=%b rgb=%h want 11 5a1b80",
               {bus.VGA_BLANK_N, bus.FRAME_START}, {bus.VGA_R, bus.VGA_G, bus.VGA_B});
    end
    bad = 0;
    for (int n = 0; n < FRAME; n++) begin
      if (n != 0) @(negedge clk);
      x = n % H_TOT;
      y = n / H_TOT;
      if ({bus.VGA_R, bus.VGA_G, bus.VGA_B} !== exp_ram_rgb(x, y) || bus.FRAME_START !== (n == 0))
        bad++;
      if (x == H_TOT - 1) begin
        checks++;
        if (bad !== 0) begin
          errors++;
          $display("FAIL capture_line y%0d: %0d bad clocks want 0", y, bad);
        end
        bad = 0;
      end
    end
  endtask

  initial begin
    bus.PATTERN = 1'b0;
    test_reset();
    test_frame_timing();
    test_addr();
    test_pattern();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_frame_tx.md
Name: vga_frame_tx

Overview:
Transmit end of the VGA path. Generates 640x480@60 Hz timing on a 25 MHz pixel clock and streams 24-bit pixels from a synchronous framebuffer RAM onto the DE2-style VGA pins. Framebuffer layout is BMP order: bottom-up rows, 24-bit B,G,R words, so an image captured by the VGA frame-capture bench can be replayed directly. It also provides a built-in colour-bar source for bring-up without memory.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, horizontal sync width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
BOTTOM_UP, 1, 1 = row 0 on screen reads the last stored row (BMP order); 0 = top-down

Ports:
CLOCK_25  in  1  pixel clock; the only clock
RESET  in  1  synchronous, active-high reset
PATTERN  in  1  0 = framebuffer source, 1 = colour bars
RD_ADDR  out  19  framebuffer word address (combinational from stage-0 counters)
RD_EN  out  1  high when stage-0 position is in the active area
RD_DATA  in  24  {B[23:16], G[15:8], R[7:0]}; valid one clock after RD_ADDR
VGA_CLK  out  1  equals CLOCK_25; outputs change on rising edge, sink samples on falling edge
VGA_HS  out  1  horizontal sync, active low
VGA_VS  out  1  vertical sync, active low
VGA_BLANK_N  out  1  high during active video
VGA_R  out  8  red
VGA_G  out  8  green
VGA_B  out  8  blue
FRAME_START  out  1  one-clock pulse coincident with output pixel (0,0)

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Stage 0 holds counters h (0..799) and v (0..524), origin = first active pixel. Active: h<640 and v<480. HS region: h 656..751. VS region: v 490..491.
- h increments every clock and wraps at 799 to 0. On that wrap, v increments and wraps at 524 to 0.
- Stage 1 registers sync, blank, FRAME_START and the bar colour from stage 0. All pin outputs lag the counters by exactly 1 clock.
- RD_ADDR = row*640 + h, with row = (479 - v) if BOTTOM_UP else v. Compute the multiply as (row<<9) + (row<<7). When inactive, RD_ADDR = 0 and RD_EN = 0.
- Pixel output when VGA_BLANK_N=1:
  - PATTERN=0: R = RD_DATA[7:0], G = RD_DATA[15:8], B = RD_DATA[23:16].
  - PATTERN=1: bar index h/80 gives white, yellow, cyan, green, magenta, red, blue, black, each channel 8'hFF or 8'h00.
- Pixel output when VGA_BLANK_N=0: R = G = B = 0 regardless of source.
- PATTERN is sampled in stage 0 and registered, so a change takes effect on the next output pixel. A mid-line change is permitted (no glitch beyond a source switch).
- Reset values, held while RESET=1: h=0, v=0, VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0, VGA_R/G/B=0, FRAME_START=0, RD_EN=0, RD_ADDR=0.
- First rising edge with RESET=0: outputs show pixel (0,0), so BLANK_N=1 and FRAME_START=1.
- Reset asserted mid-frame: next edge forces the reset values and restarts from (0,0). No partial-line completion.
- Frame period is 800*525 = 420000 clocks. HS low 96 clocks per line. VS low 1600 clocks per frame, starting 16 clocks after the rising edge of a BLANK_N... more precisely, at the output of h=0, v=490.

Test Plan:
- Hold RESET 5 clocks then release -> during reset HS=VS=1, BLANK_N=0, RGB=0. First released edge: BLANK_N=1, FRAME_START=1.
- Run 2 frames -> per line BLANK_N high 640 clocks, HS low 96 clocks starting 16 clocks after BLANK_N falls. VS low 1600 clocks. FRAME_START period 420000 clocks. 480 BLANK_N pulses per frame.
- BOTTOM_UP=1 address check -> at output pixel (0,0), RD_ADDR = 306560. Pixel (639,0) gives 307199. Pixel (0,479) gives 0. Pixel (639,479) gives 639. RD_EN=0 outside active area.
- RAM model with 1-cycle latency returning {B,G,R} = {addr[7:0], addr[15:8], 8'h5A} -> each active output pixel matches, byte order preserved; blank pixels are 0.
- PATTERN=1, sample line 10 -> x=0 gives FF/FF/FF, x=80 gives R=FF G=FF B=00, x=400 gives FF/00/00, x=600 gives 00/00/00. Toggling PATTERN at x=300 switches source at x=301 output.
- Assert RESET for 1 clock at v=200, h=320 -> next edge shows reset values. Following edge shows pixel (0,0) with FRAME_START=1. Capture of the next full frame by the VGA frame-capture bench reproduces the RAM image.
